key_matrix_scan: RTL and testbench
==================================

KEY_MATRIX_SCAN -- requirements
Module: key_matrix_scan

Interface
REQ-001 SHALL have parameter SCAN_TICKS, default 50_000, meaning Clk cycles each row is driven (1 ms at 50 MHz); legal values are 4 or more.
REQ-002 SHALL have parameter DEB_FRAMES, default 5, meaning consecutive identical full-matrix frames required before the debounced map updates; legal values are 2 to 15.
REQ-003 SHALL have port Clk, input, 1 bit: system clock, single clock domain.
REQ-004 SHALL have port Reset_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port Col, input, 4 bits: keypad column lines, asynchronous, active-low with external pull-ups.
REQ-006 SHALL have port Row, output, 4 bits: keypad row drive, one-hot active-low.
REQ-007 SHALL have port Key_map, output, 16 bits: debounced pressed map, bit index = row*4 + col, 1 = pressed.
REQ-008 SHALL have port Key_valid, output, 1 bit: one-cycle pulse for a new single-key press.
REQ-009 SHALL have port Key_code, output, 4 bits: index of the pressed key; valid when Key_valid is high and held until the next Key_valid.
REQ-010 SHALL have port Key_release, output, 1 bit: one-cycle pulse when Key_map goes from nonzero to zero.
REQ-011 SHALL have port Key_multi, output, 1 bit: level, high while Key_map has two or more bits set.

Function
REQ-012 SHALL pass Col through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-013 SHALL count slots with tick_cnt over 0..SCAN_TICKS-1 and wrap to 0.
REQ-014 SHALL advance row_idx (0..3, wrapping 3 to 0) on the cycle tick_cnt wraps.
REQ-015 SHALL drive Row low only at row_idx; Row SHALL change only on the row_idx advance.
REQ-016 SHALL capture ~Col_sync into raw[row_idx*4 +: 4] at tick_cnt == SCAN_TICKS-1; this gives SCAN_TICKS-3 or more cycles of settling after the row change.
REQ-017 SHALL treat the capture at row_idx == 3 as frame end; the frame value is raw including the row-3 bits just captured.
REQ-018 SHALL compare each frame with the previous frame at frame end.
  - equal: stable_cnt increments, saturating at DEB_FRAMES.
  - different: stable_cnt is set to 1.
  - in both cases the previous frame register is loaded with the current frame.
REQ-019 SHALL load Key_map with the frame on the frame end where stable_cnt first reaches DEB_FRAMES, and only if the frame differs from Key_map.
REQ-020 SHALL make no further Key_map update while saturated; the next update requires a changed frame followed by re-stabilisation.
REQ-021 SHALL evaluate events one cycle after a Key_map update.
  - new map has exactly one bit set: Key_valid = 1 for one cycle and Key_code = that bit index.
  - this covers a change from one key to a different single key, which also pulses.
  - new map is zero and the old map was nonzero: Key_release = 1 for one cycle.
  - new map has two or more bits set: no Key_valid and no Key_code change.
REQ-022 SHALL derive Key_multi from Key_map as popcount(Key_map) >= 2, registered, so it follows Key_map by one cycle.
REQ-023 SHALL never assert Key_valid and Key_release in the same cycle.
REQ-024 SHALL make the minimum press-to-Key_valid latency DEB_FRAMES frames plus at most one frame for alignment plus 3 cycles (2 synchronizer + 1 event).

Reset
REQ-025 SHALL, while Reset_n == 0 at a Clk edge, load the following values:
  - tick_cnt = 0, row_idx = 0, Row = 4'b1110;
  - raw, previous frame, Key_map = 0; stable_cnt = 0;
  - Key_valid = 0, Key_release = 0, Key_code = 0, Key_multi = 0;
  - synchronizer flops = 4'b1111.
REQ-026 SHALL, on reset asserted mid-scan or mid-debounce, discard all partial state; scanning restarts at row 0, tick 0 on the first cycle with Reset_n == 1.

Verification (SCAN_TICKS = 8, DEB_FRAMES = 3)
REQ-027 Reset then idle with Col = 4'hF: Row cycles 1110, 1101, 1011, 0111, holding each for 8 cycles; Key_map stays 0 and no pulses occur.
REQ-028 Key row 2 / col 1 held (Col[1] low while Row[2] low): exactly one Key_valid with Key_code = 9 and Key_map = 16'h0200; on release, one Key_release and Key_map = 0.
REQ-029 Bounce: toggle the key every frame for 4 frames, then hold: no Key_valid during the bounce; exactly one Key_valid (code 9) after 3 stable frames.
REQ-030 Keys 0 and 15 pressed together: Key_map = 16'h8001, Key_multi = 1, no Key_valid; then release key 15: Key_valid with Key_code = 0 and Key_multi = 0.
REQ-031 Hold key 5 for 20 frames: exactly one Key_valid, no repeats.
REQ-032 Assert Reset_n low for 1 cycle mid-debounce with key 3 held: all outputs return to reset values; Key_valid with Key_code = 3 follows after 3 fresh stable frames.

Source files
------------

// File: rtl/key_matrix_scan.sv
// 4x4 keypad scanner: active-low one-hot row drive, full-frame debounce, single-key press/release events.
// Latency: DEB_FRAMES frames + up to 1 frame of alignment + 3 cycles. No backpressure; event pulses are not held.
module key_matrix_scan #(
    parameter int SCAN_TICKS = 50_000,
    parameter int DEB_FRAMES = 5
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [3:0]  Col,
    output logic [3:0]  Row,
    output logic [15:0] Key_map,
    output logic        Key_valid,
    output logic [3:0]  Key_code,
    output logic        Key_release,
    output logic        Key_multi
);
    localparam int            TW        = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_TICKS - 1);
    localparam logic [TW-1:0] TICK_ONE  = TW'(1);
    localparam logic [3:0]    DEB_MAX   = 4'(DEB_FRAMES);

    logic [3:0]    col_meta_q, col_sync_q;
    logic [TW-1:0] tick_q, tick_d;
    logic [1:0]    row_idx_q, row_idx_d;
    logic [3:0]    row_q, row_d;
    logic [15:0]   raw_q, raw_d;
    logic [15:0]   prev_q, prev_d;
    logic [3:0]    stable_q, stable_d;
    logic [15:0]   map_q, map_d;
    logic [15:0]   old_map_q, old_map_d;
    logic          upd_q, upd_d;
    logic          valid_q, valid_d;
    logic          release_q, release_d;
    logic [3:0]    code_q, code_d;
    logic          multi_q, multi_d;
    logic [15:0]   frame;
    logic [4:0]    map_ones;
    logic [3:0]    map_idx;

    // Scan, capture and debounce; a frame is the raw map with the row-3 bits sampled this cycle.
    always_comb begin
        tick_d    = tick_q + TICK_ONE;
        row_idx_d = row_idx_q;
        row_d     = row_q;
        raw_d     = raw_q;
        prev_d    = prev_q;
        stable_d  = stable_q;
        map_d     = map_q;
        old_map_d = old_map_q;
        upd_d     = 1'b0;
        frame     = {~col_sync_q, raw_q[11:0]};
        if (tick_q == TICK_LAST) begin
            tick_d    = '0;
            row_idx_d = row_idx_q + 2'd1;
            row_d     = ~(4'b0001 << row_idx_d);
            raw_d[{row_idx_q, 2'b00} +: 4] = ~col_sync_q;
            if (row_idx_q == 2'd3) begin
                if (frame == prev_q) begin
                    stable_d = (stable_q == DEB_MAX) ? DEB_MAX : stable_q + 4'd1;
                end else begin
                    stable_d = 4'd1;
                end
                prev_d = frame;
                // Only the frame that first reaches the threshold may update the map.
                if (stable_d == DEB_MAX && stable_q != DEB_MAX && frame != map_q) begin
                    map_d     = frame;
                    old_map_d = map_q;
                    upd_d     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        map_ones = '0;
        map_idx  = '0;
        for (int i = 0; i < 16; i++) begin
            if (map_q[i]) begin
                map_ones = map_ones + 5'd1;
                map_idx  = 4'(i);
            end
        end
    end

    // Events are judged on the map one cycle after it changes; multi-key maps stay silent.
    always_comb begin
        valid_d   = upd_q && (map_ones == 5'd1);
        release_d = upd_q && (map_q == '0) && (old_map_q != '0);
        code_d    = valid_d ? map_idx : code_q;
        multi_d   = (map_ones >= 5'd2);
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            col_meta_q <= 4'b1111;
            col_sync_q <= 4'b1111;
            tick_q     <= '0;
            row_idx_q  <= 2'd0;
            row_q      <= 4'b1110;
            raw_q      <= '0;
            prev_q     <= '0;
            stable_q   <= '0;
            map_q      <= '0;
            old_map_q  <= '0;
            upd_q      <= 1'b0;
            valid_q    <= 1'b0;
            release_q  <= 1'b0;
            code_q     <= '0;
            multi_q    <= 1'b0;
        end else begin
            col_meta_q <= Col;
            col_sync_q <= col_meta_q;
            tick_q     <= tick_d;
            row_idx_q  <= row_idx_d;
            row_q      <= row_d;
            raw_q      <= raw_d;
            prev_q     <= prev_d;
            stable_q   <= stable_d;
            map_q      <= map_d;
            old_map_q  <= old_map_d;
            upd_q      <= upd_d;
            valid_q    <= valid_d;
            release_q  <= release_d;
            code_q     <= code_d;
            multi_q    <= multi_d;
        end
    end

    assign Row         = row_q;
    assign Key_map     = map_q;
    assign Key_valid   = valid_q;
    assign Key_code    = code_q;
    assign Key_release = release_q;
    assign Key_multi   = multi_q;
endmodule

// File: tb/tb_key_matrix_scan.sv
// Bench for key_matrix_scan: a simulated keypad driven by Row, a frame-level reference model checked every cycle,
// a table of directed segments with end-of-segment expectations, a mid-debounce reset and random key segments.
module tb_key_matrix_scan;
    localparam int ST    = 8;
    localparam int DEB   = 3;
    localparam int FRAME = 4 * ST;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  col_drv;
    logic [3:0]  row_w;
    logic [15:0] map_w;
    logic        valid_w, release_w, multi_w;
    logic [3:0]  code_w;

    key_matrix_scan #(.SCAN_TICKS(ST), .DEB_FRAMES(DEB)) dut (
        .Clk(clk), .Reset_n(rst_n), .Col(col_drv), .Row(row_w), .Key_map(map_w),
        .Key_valid(valid_w), .Key_code(code_w), .Key_release(release_w), .Key_multi(multi_w)
    );

    always #5 clk = ~clk;

    logic [15:0] keys = '0;
    // Physical keypad: a pressed key shorts its row line to its column line.
    always_comb begin
        col_drv = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!row_w[r] && keys[r*4+c]) col_drv[c] = 1'b0;
    end

    int total = 0;
    int bad   = 0;
    int n;
    int seg_valid, seg_release;
    logic [15:0] m_prev, m_map, m_old;
    int          m_cnt;
    logic        m_upd;
    logic [3:0]  m_code;

    typedef struct {
        logic [15:0] keys;
        int          frames;
        int          exp_valid;
        int          exp_release;
        logic [3:0]  exp_code;
        logic [15:0] exp_map;
        logic        exp_multi;
    } vec_t;
    vec_t vecs[14];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, n);
        end
    endtask

    function automatic logic [3:0] lowest_bit(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return 4'(i);
        return 4'd0;
    endfunction

    task automatic model_reset();
        n = -1; m_prev = '0; m_map = '0; m_old = '0; m_cnt = 0; m_upd = 1'b0; m_code = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        chk("rst_row", {12'd0, row_w}, 16'h000E);
        chk("rst_map", map_w, 16'h0000);
        chk("rst_valid", {15'd0, valid_w}, 16'd0);
        chk("rst_release", {15'd0, release_w}, 16'd0);
        chk("rst_code", {12'd0, code_w}, 16'd0);
        chk("rst_multi", {15'd0, multi_w}, 16'd0);
    endtask

    // One clock: advance the frame model for the edge just taken, then compare every output.
    task automatic run_cycle();
        logic        e_valid, e_rel, e_multi;
        logic [3:0]  e_row;
        int          was;
        @(posedge clk); #1;
        n++;
        e_valid = m_upd && ($countones(m_map) == 1);
        e_rel   = m_upd && (m_map == '0) && (m_old != '0);
        e_multi = ($countones(m_map) >= 2);
        if (e_valid) m_code = lowest_bit(m_map);
        m_upd = 1'b0;
        if (n % FRAME == FRAME - 1) begin
            was = m_cnt;
            if (keys == m_prev) begin
                if (m_cnt < DEB) m_cnt++;
            end else begin
                m_cnt = 1;
            end
            m_prev = keys;
            if (m_cnt == DEB && was < DEB && keys != m_map) begin
                m_old = m_map;
                m_map = keys;
                m_upd = 1'b1;
            end
        end
        e_row = 4'hF;
        e_row[((n + 1) / ST) % 4] = 1'b0;
        chk("row", {12'd0, row_w}, {12'd0, e_row});
        chk("key_map", map_w, m_map);
        chk("key_valid", {15'd0, valid_w}, {15'd0, e_valid});
        chk("key_release", {15'd0, release_w}, {15'd0, e_rel});
        chk("key_multi", {15'd0, multi_w}, {15'd0, e_multi});
        chk("key_code", {12'd0, code_w}, {12'd0, m_code});
        if (valid_w && release_w) chk("valid_and_release", 16'd1, 16'd0);
        if (valid_w) seg_valid++;
        if (release_w) seg_release++;
    endtask

    // Segments start just after the first edge of a frame and end one cycle past their last frame end.
    task automatic run_segment(input logic [15:0] k, input int frames);
        keys = k;
        seg_valid = 0;
        seg_release = 0;
        for (int i = 0; i < frames * FRAME; i++) run_cycle();
    endtask

    initial begin
        vecs[0]  = '{16'h0000, 4,  0, 0, 4'd0, 16'h0000, 1'b0};
        vecs[1]  = '{16'h0200, 5,  1, 0, 4'd9, 16'h0200, 1'b0};
        vecs[2]  = '{16'h0000, 4,  0, 1, 4'd9, 16'h0000, 1'b0};
        vecs[3]  = '{16'h0200, 1,  0, 0, 4'd9, 16'h0000, 1'b0};
        vecs[4]  = '{16'h0000, 1,  0, 0, 4'd9, 16'h0000, 1'b0};
        vecs[5]  = '{16'h0200, 1,  0, 0, 4'd9, 16'h0000, 1'b0};
        vecs[6]  = '{16'h0000, 1,  0, 0, 4'd9, 16'h0000, 1'b0};
        vecs[7]  = '{16'h0200, 4,  1, 0, 4'd9, 16'h0200, 1'b0};
        vecs[8]  = '{16'h0000, 4,  0, 1, 4'd9, 16'h0000, 1'b0};
        vecs[9]  = '{16'h8001, 4,  0, 0, 4'd9, 16'h8001, 1'b1};
        vecs[10] = '{16'h0001, 4,  1, 0, 4'd0, 16'h0001, 1'b0};
        vecs[11] = '{16'h0000, 4,  0, 1, 4'd0, 16'h0000, 1'b0};
        vecs[12] = '{16'h0020, 20, 1, 0, 4'd5, 16'h0020, 1'b0};
        vecs[13] = '{16'h0000, 4,  0, 1, 4'd5, 16'h0000, 1'b0};

        model_reset();
        seg_valid = 0;
        seg_release = 0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        run_cycle();

        for (int v = 0; v < 14; v++) begin
            run_segment(vecs[v].keys, vecs[v].frames);
            chk($sformatf("vec%0d_valid_count", v), 16'(seg_valid), 16'(vecs[v].exp_valid));
            chk($sformatf("vec%0d_release_count", v), 16'(seg_release), 16'(vecs[v].exp_release));
            chk($sformatf("vec%0d_code", v), {12'd0, code_w}, {12'd0, vecs[v].exp_code});
            chk($sformatf("vec%0d_map", v), map_w, vecs[v].exp_map);
            chk($sformatf("vec%0d_multi", v), {15'd0, multi_w}, {15'd0, vecs[v].exp_multi});
        end

        // Key 3 held, reset one cycle partway into the third frame, then three fresh frames.
        keys = 16'h0008;
        seg_valid = 0;
        for (int i = 0; i < 2 * FRAME + 13; i++) run_cycle();
        chk("pre_reset_valid_count", 16'(seg_valid), 16'd0);
        do_reset();
        run_cycle();
        run_segment(16'h0008, 3);
        chk("post_reset_valid_count", 16'(seg_valid), 16'd1);
        chk("post_reset_code", {12'd0, code_w}, 16'd3);
        chk("post_reset_map", map_w, 16'h0008);

        for (int s = 0; s < 40; s++) begin
            logic [15:0] k;
            int          b0, b1;
            k  = '0;
            b0 = int'($urandom_range(0, 15));
            b1 = (b0 + int'($urandom_range(1, 15))) % 16;
            case ($urandom_range(0, 3))
                0: k = '0;
                1: k[b0] = 1'b1;
                2: begin k[b0] = 1'b1; k[b1] = 1'b1; end
                default: k = keys;
            endcase
            run_segment(k, int'($urandom_range(1, 5)));
        end
        run_segment(16'h0000, 4);
        chk("final_map", map_w, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
